// File: rtl/ula_arbiter.sv
// Round-robin arbiter sharing one combinational ULA among NUM_REQ cores.
// Every grant walks IDLE -> EXEC -> DONE, so one operation completes per three cycles.
module ula_arbiter #(
    parameter int NUM_REQ    = 4,
    parameter int DATA_WIDTH = 8
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [NUM_REQ-1:0]            req,
    input  logic [4*NUM_REQ-1:0]          op_in,
    input  logic [DATA_WIDTH*NUM_REQ-1:0] a_in,
    input  logic [DATA_WIDTH*NUM_REQ-1:0] b_in,
    output logic [NUM_REQ-1:0]            gnt,
    output logic [NUM_REQ-1:0]            done,
    output logic [DATA_WIDTH-1:0]         result_out,
    output logic [3:0]                    flags_out,
    output logic                          err,
    output logic                          busy,
    output logic [3:0]                    ula_operation,
    output logic [DATA_WIDTH-1:0]         operand1,
    output logic [DATA_WIDTH-1:0]         operand2,
    input  logic [DATA_WIDTH-1:0]         ula_result,
    input  logic [3:0]                    ula_flags
);

    localparam int PTR_W = $clog2(NUM_REQ);
    localparam logic [PTR_W-1:0] LAST_IDX = PTR_W'(NUM_REQ - 1);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_EXEC = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    // Lowest rotational offset from p wins; scanning downward lets it overwrite the rest.
    function automatic logic [PTR_W-1:0] pick_next(input logic [NUM_REQ-1:0] r,
                                                   input logic [PTR_W-1:0]   p);
        logic [PTR_W-1:0] res;
        int               idx;
        res = p;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            idx = (int'(p) + k) % NUM_REQ;
            if (r[PTR_W'(idx)]) begin
                res = PTR_W'(idx);
            end else begin
                res = res;
            end
        end
        return res;
    endfunction

    function automatic logic op_is_valid(input logic [3:0] op);
        return (op >= 4'd1) && (op <= 4'd12);
    endfunction

    logic [1:0]            state_q,    state_d;
    logic [PTR_W-1:0]      rr_ptr_q,   rr_ptr_d;
    logic [PTR_W-1:0]      gidx_q,     gidx_d;
    logic [NUM_REQ-1:0]    gnt_q,      gnt_d;
    logic [NUM_REQ-1:0]    done_q,     done_d;
    logic [DATA_WIDTH-1:0] result_q,   result_d;
    logic [3:0]            flags_q,    flags_d;
    logic                  err_q,      err_d;
    logic                  busy_q,     busy_d;
    logic [3:0]            ula_op_q,   ula_op_d;
    logic [DATA_WIDTH-1:0] opnd1_q,    opnd1_d;
    logic [DATA_WIDTH-1:0] opnd2_q,    opnd2_d;
    logic                  op_valid_q, op_valid_d;

    logic [PTR_W-1:0]      pick_idx_s;
    logic [3:0]            op_arr_s [NUM_REQ];
    logic [DATA_WIDTH-1:0] a_arr_s  [NUM_REQ];
    logic [DATA_WIDTH-1:0] b_arr_s  [NUM_REQ];

    for (genvar i = 0; i < NUM_REQ; i++) begin : g_unpack
        assign op_arr_s[i] = op_in[4*i +: 4];
        assign a_arr_s[i]  = a_in[DATA_WIDTH*i +: DATA_WIDTH];
        assign b_arr_s[i]  = b_in[DATA_WIDTH*i +: DATA_WIDTH];
    end

    // Round-robin choice among the currently pending requests.
    always_comb begin
        pick_idx_s = pick_next(req, rr_ptr_q);
    end

    // Next-state and datapath update for the three-state transaction sequencer.
    always_comb begin
        state_d    = state_q;
        rr_ptr_d   = rr_ptr_q;
        gidx_d     = gidx_q;
        gnt_d      = gnt_q;
        done_d     = done_q;
        result_d   = result_q;
        flags_d    = flags_q;
        err_d      = err_q;
        busy_d     = busy_q;
        ula_op_d   = ula_op_q;
        opnd1_d    = opnd1_q;
        opnd2_d    = opnd2_q;
        op_valid_d = op_valid_q;
        case (state_q)
            ST_IDLE: begin
                if (|req) begin
                    gidx_d     = pick_idx_s;
                    gnt_d      = {{(NUM_REQ-1){1'b0}}, 1'b1} << pick_idx_s;
                    op_valid_d = op_is_valid(op_arr_s[pick_idx_s]);
                    ula_op_d   = op_is_valid(op_arr_s[pick_idx_s]) ? op_arr_s[pick_idx_s] : 4'd0;
                    opnd1_d    = a_arr_s[pick_idx_s];
                    opnd2_d    = b_arr_s[pick_idx_s];
                    busy_d     = 1'b1;
                    state_d    = ST_EXEC;
                end else begin
                    state_d    = ST_IDLE;
                end
            end
            ST_EXEC: begin
                // Invalid opcodes report zeros so stale ULA flags never reach the core.
                result_d = op_valid_q ? ula_result : '0;
                flags_d  = op_valid_q ? ula_flags : 4'd0;
                err_d    = ~op_valid_q;
                done_d   = gnt_q;
                ula_op_d = 4'd0;
                state_d  = ST_DONE;
            end
            ST_DONE: begin
                rr_ptr_d = (gidx_q == LAST_IDX) ? '0 : gidx_q + 1'b1;
                gnt_d    = '0;
                done_d   = '0;
                result_d = '0;
                flags_d  = 4'd0;
                err_d    = 1'b0;
                busy_d   = 1'b0;
                state_d  = ST_IDLE;
            end
            default: begin
                gnt_d    = '0;
                done_d   = '0;
                result_d = '0;
                flags_d  = 4'd0;
                err_d    = 1'b0;
                busy_d   = 1'b0;
                ula_op_d = 4'd0;
                state_d  = ST_IDLE;
            end
        endcase
    end

    // State registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            rr_ptr_q   <= '0;
            gidx_q     <= '0;
            gnt_q      <= '0;
            done_q     <= '0;
            result_q   <= '0;
            flags_q    <= 4'd0;
            err_q      <= 1'b0;
            busy_q     <= 1'b0;
            ula_op_q   <= 4'd0;
            opnd1_q    <= '0;
            opnd2_q    <= '0;
            op_valid_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            rr_ptr_q   <= rr_ptr_d;
            gidx_q     <= gidx_d;
            gnt_q      <= gnt_d;
            done_q     <= done_d;
            result_q   <= result_d;
            flags_q    <= flags_d;
            err_q      <= err_d;
            busy_q     <= busy_d;
            ula_op_q   <= ula_op_d;
            opnd1_q    <= opnd1_d;
            opnd2_q    <= opnd2_d;
            op_valid_q <= op_valid_d;
        end
    end

    assign gnt           = gnt_q;
    assign done          = done_q;
    assign result_out    = result_q;
    assign flags_out     = flags_q;
    assign err           = err_q;
    assign busy          = busy_q;
    assign ula_operation = ula_op_q;
    assign operand1      = opnd1_q;
    assign operand2      = opnd2_q;

endmodule

// File: tb/tb_ula_arbiter.sv
// Bench for ula_arbiter: directed vector table, multi-cycle corner sequences,
// then randomized traffic against a transaction-level reference model.
module tb_ula_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic [3:0]  req;
    logic [15:0] op_in;
    logic [31:0] a_in, b_in;
    logic [3:0]  gnt, done, flags_out, ula_operation, ula_flags;
    logic [7:0]  result_out, operand1, operand2, ula_result;
    logic        err, busy;

    int checks = 0;
    int errors = 0;

    ula_arbiter #(.NUM_REQ(4), .DATA_WIDTH(8)) dut (
        .clk(clk), .reset(reset), .req(req), .op_in(op_in), .a_in(a_in), .b_in(b_in),
        .gnt(gnt), .done(done), .result_out(result_out), .flags_out(flags_out),
        .err(err), .busy(busy), .ula_operation(ula_operation),
        .operand1(operand1), .operand2(operand2),
        .ula_result(ula_result), .ula_flags(ula_flags)
    );

    always #5 clk = ~clk;

    // Behavioural ULA; opcode 0 returns garbage so leaks are visible.
    function automatic logic [11:0] ula_fn(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b);
        logic [8:0] w;
        logic [7:0] r;
        logic       c, v;
        c = 1'b0; v = 1'b0; r = 8'h00;
        case (op)
            4'd1:  begin w = {1'b0, a} + {1'b0, b}; r = w[7:0]; c = w[8];
                         v = (a[7] == b[7]) && (r[7] != a[7]); end
            4'd2:  begin r = a - b; c = (a < b); v = (a[7] != b[7]) && (r[7] != a[7]); end
            4'd3:  r = a & b;
            4'd4:  begin if (b == 8'h00) begin r = 8'h00; c = 1'b1; end else r = a / b; end
            4'd5:  r = a | b;
            4'd6:  r = a ^ b;
            4'd7:  r = ~a;
            4'd8:  r = a << 1;
            4'd9:  r = a >> 1;
            4'd10: r = 8'(a * b);
            4'd11: r = a + 8'd1;
            4'd12: r = a - 8'd1;
            default: return {4'hF, 8'hA5};
        endcase
        return {v, c, r[7], (r == 8'h00), r};
    endfunction

    always_comb begin
        {ula_flags, ula_result} = ula_fn(ula_operation, operand1, operand2);
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_gnt"}, 32'(gnt), 32'd0);
        chk({tag, "_done"}, 32'(done), 32'd0);
        chk({tag, "_result"}, 32'(result_out), 32'd0);
        chk({tag, "_flags"}, 32'(flags_out), 32'd0);
        chk({tag, "_err"}, 32'(err), 32'd0);
        chk({tag, "_busy"}, 32'(busy), 32'd0);
        chk({tag, "_ulaop"}, 32'(ula_operation), 32'd0);
        chk({tag, "_opnd1"}, 32'(operand1), 32'd0);
        chk({tag, "_opnd2"}, 32'(operand2), 32'd0);
    endtask

    typedef struct {
        logic [3:0] req;
        logic [3:0] op;
        logic [7:0] a, b;
        logic [3:0] ula_op;
        logic [7:0] res;
        logic [3:0] flags;
        logic       err;
    } vec_t;

    vec_t vecs[9];

    // Directed single transaction from IDLE; ends at a negedge back in IDLE.
    task automatic run_vec(input vec_t v, input int i);
        string t;
        t = $sformatf("vec%0d", i);
        req = v.req; op_in = {4{v.op}}; a_in = {4{v.a}}; b_in = {4{v.b}};
        cyc();
        req = 4'd0;
        chk({t, "_exec_gnt"}, 32'(gnt), 32'(v.req));
        chk({t, "_exec_ulaop"}, 32'(ula_operation), 32'(v.ula_op));
        chk({t, "_exec_busy"}, 32'(busy), 32'd1);
        chk({t, "_exec_opnd1"}, 32'(operand1), 32'(v.a));
        chk({t, "_exec_done"}, 32'(done), 32'd0);
        cyc();
        chk({t, "_done"}, 32'(done), 32'(v.req));
        chk({t, "_result"}, 32'(result_out), 32'(v.res));
        chk({t, "_flags"}, 32'(flags_out), 32'(v.flags));
        chk({t, "_err"}, 32'(err), 32'(v.err));
        chk({t, "_done_ulaop"}, 32'(ula_operation), 32'd0);
        cyc();
        chk({t, "_idle_busy"}, 32'(busy), 32'd0);
        chk({t, "_idle_gnt"}, 32'(gnt), 32'd0);
        chk({t, "_idle_done"}, 32'(done), 32'd0);
    endtask

    // Reference model: each accepted request becomes a fixed three-cycle output script.
    typedef struct {
        logic [3:0] gnt, done, flags, ula_op;
        logic [7:0] result, op1, op2;
        logic       err, busy;
    } exp_t;

    exp_t m_q[$];
    exp_t cur;
    int   m_ptr;
    logic [7:0] m_a, m_b;

    function automatic int winner(input logic [3:0] r, input int p);
        int idx;
        for (int k = 0; k < 4; k++) begin
            idx = (p + k) % 4;
            if (((r >> idx) & 4'd1) != 4'd0) return idx;
        end
        return -1;
    endfunction

    task automatic model_edge();
        exp_t e;
        int w;
        logic [3:0] op;
        logic [7:0] a, b;
        logic valid;
        logic [11:0] u;
        e = '{default: '0};
        if (reset) begin
            m_q.delete();
            m_ptr = 0; m_a = 8'h00; m_b = 8'h00;
            cur = e;
            return;
        end
        if (m_q.size() == 0) begin
            if (req != 4'd0) begin
                w = winner(req, m_ptr);
                op = 4'(op_in >> (4 * w));
                a  = 8'(a_in >> (8 * w));
                b  = 8'(b_in >> (8 * w));
                valid = (op >= 4'd1) && (op <= 4'd12);
                u = ula_fn(op, a, b);
                e.gnt = 4'(32'd1 << w); e.busy = 1'b1; e.op1 = a; e.op2 = b;
                e.ula_op = valid ? op : 4'd0;
                m_q.push_back(e);
                e.ula_op = 4'd0; e.done = e.gnt;
                e.result = valid ? u[7:0] : 8'h00;
                e.flags  = valid ? u[11:8] : 4'd0;
                e.err    = ~valid;
                m_q.push_back(e);
                e = '{default: '0}; e.op1 = a; e.op2 = b;
                m_q.push_back(e);
                m_ptr = (w + 1) % 4; m_a = a; m_b = b;
            end else begin
                e.op1 = m_a; e.op2 = m_b;
                m_q.push_back(e);
            end
        end
        cur = m_q.pop_front();
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog timeout checks=%0d", checks);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] rnd;
        vecs[0] = '{4'b0010, 4'd1,  8'h05, 8'h03, 4'd1,  8'h08, 4'b0000, 1'b0};
        vecs[1] = '{4'b0001, 4'd4,  8'h10, 8'h00, 4'd4,  8'h00, 4'b0101, 1'b0};
        vecs[2] = '{4'b0100, 4'd15, 8'h12, 8'h34, 4'd0,  8'h00, 4'b0000, 1'b1};
        vecs[3] = '{4'b1000, 4'd0,  8'h12, 8'h34, 4'd0,  8'h00, 4'b0000, 1'b1};
        vecs[4] = '{4'b0001, 4'd2,  8'h03, 8'h05, 4'd2,  8'hFE, 4'b0110, 1'b0};
        vecs[5] = '{4'b0010, 4'd12, 8'h00, 8'h77, 4'd12, 8'hFF, 4'b0010, 1'b0};
        vecs[6] = '{4'b0100, 4'd13, 8'h44, 8'h01, 4'd0,  8'h00, 4'b0000, 1'b1};
        vecs[7] = '{4'b1000, 4'd1,  8'h7F, 8'h01, 4'd1,  8'h80, 4'b1010, 1'b0};
        vecs[8] = '{4'b0001, 4'd1,  8'hFF, 8'h01, 4'd1,  8'h00, 4'b0101, 1'b0};

        reset = 1'b1; req = 4'hF; op_in = 16'h1111; a_in = 32'h01020304; b_in = 32'h05060708;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk_all_zero("reset");
        reset = 1'b0; req = 4'd0;

        for (int i = 0; i < 9; i++) run_vec(vecs[i], i);

        // All four requesters held high from reset: served 0,1,2,3.
        reset = 1'b1; req = 4'hF; op_in = 16'h1111; a_in = 32'h04030201; b_in = {4{8'h10}};
        cyc();
        reset = 1'b0;
        for (int k = 0; k < 4; k++) begin
            cyc();
            chk($sformatf("all_gnt%0d", k), 32'(gnt), 32'd1 << k);
            cyc();
            chk($sformatf("all_done%0d", k), 32'(done), 32'd1 << k);
            chk($sformatf("all_res%0d", k), 32'(result_out), 32'h11 + 32'(k));
            cyc();
            chk($sformatf("all_idle_done%0d", k), 32'(done), 32'd0);
        end
        req = 4'd0;

        // Fairness: after core 2, cores 0 and 3 together -> 3 then 0.
        reset = 1'b1; cyc(); reset = 1'b0;
        req = 4'b0100; cyc(); req = 4'd0;
        chk("fair_first", 32'(gnt), 32'b0100);
        cyc(); cyc();
        req = 4'b1001; cyc();
        chk("fair_gnt3", 32'(gnt), 32'b1000);
        cyc(); cyc(); cyc();
        chk("fair_gnt0", 32'(gnt), 32'b0001);
        req = 4'd0; cyc(); cyc();

        // Reset during EXEC aborts without done and clears the pointer.
        req = 4'b0001; cyc(); req = 4'd0; cyc(); cyc();
        req = 4'b0101; cyc();
        chk("rst_exec_gnt", 32'(gnt), 32'b0100);
        reset = 1'b1; cyc();
        chk_all_zero("rst_exec");
        reset = 1'b0; cyc();
        chk("rst_after_gnt", 32'(gnt), 32'b0001);
        req = 4'd0; cyc();
        chk("rst_after_done", 32'(done), 32'b0001);
        cyc();

        // Request dropped and inputs changed during EXEC: latched values complete.
        req = 4'b0010; op_in = 16'h1111; a_in = {4{8'h05}}; b_in = {4{8'h03}};
        cyc();
        req = 4'd0; op_in = 16'h0000; a_in = 32'hFFFFFFFF;
        chk("drop_gnt", 32'(gnt), 32'b0010);
        cyc();
        chk("drop_done", 32'(done), 32'b0010);
        chk("drop_result", 32'(result_out), 32'h08);
        cyc();

        // Randomized traffic with occasional resets.
        for (int i = 0; i < 1500; i++) begin
            rnd = $urandom();
            req = (rnd[31:30] == 2'b00) ? 4'd0 : rnd[3:0];
            op_in = 16'($urandom());
            a_in = $urandom();
            b_in = $urandom();
            reset = (i == 0) || ($urandom_range(0, 49) == 0);
            @(posedge clk);
            model_edge();
            @(negedge clk);
            chk("rnd_gnt", 32'(gnt), 32'(cur.gnt));
            chk("rnd_done", 32'(done), 32'(cur.done));
            chk("rnd_result", 32'(result_out), 32'(cur.result));
            chk("rnd_flags", 32'(flags_out), 32'(cur.flags));
            chk("rnd_err", 32'(err), 32'(cur.err));
            chk("rnd_busy", 32'(busy), 32'(cur.busy));
            chk("rnd_ulaop", 32'(ula_operation), 32'(cur.ula_op));
            chk("rnd_opnd1", 32'(operand1), 32'(cur.op1));
            chk("rnd_opnd2", 32'(operand2), 32'(cur.op2));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
